// File: rtl/coin_acceptor_pkg.sv
// Shared definitions for the coin acceptor: coin codes on the coin bus,
// rupee values, and the issue FSM state encoding.
package coin_acceptor_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;

  localparam logic [6:0] VAL_5  = 7'd5;
  localparam logic [6:0] VAL_10 = 7'd10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } issue_state_t;

  // Rupee value of a coin code; an empty or illegal code is worth nothing.
  function automatic logic [6:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_5:  return VAL_5;
      COIN_10: return VAL_10;
      default: return 7'd0;
    endcase
  endfunction

endpackage

// File: rtl/coin_debounce.sv
// Sensor debouncer: 2-flop synchronizer, saturating high-level counter and a
// one-cycle event pulse registered on the cycle the counter reaches DEB_CYC.
// Ports:
//   clk    - system clock
//   reset  - asynchronous active-low reset
//   sns    - raw asynchronous sensor level
//   evt    - one-cycle pulse per accepted sensor pulse
module coin_debounce #(
  parameter int DEB_CYC = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sns,
  output logic evt
);

  localparam logic [3:0] CNT_MAX = 4'(DEB_CYC);
  localparam logic [3:0] CNT_TC  = 4'(DEB_CYC - 1);

  logic [1:0] sync;
  logic [3:0] cnt;

  // Once saturated the counter stops, so no further event is possible until
  // the level drops and clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync <= 2'b00;
      cnt  <= 4'd0;
      evt  <= 1'b0;
    end else begin
      sync <= {sync[0], sns};
      evt  <= 1'b0;
      if (!sync[1]) begin
        cnt <= 4'd0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 4'd1;
        evt <= (cnt == CNT_TC);
      end
    end
  end

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: debounces the Rs 5 / Rs 10 sensors, admits coins
// into a small queue against a credit ceiling, and issues them one at a time
// to the vending FSM while tracking delivered credit.
// Ports:
//   clk, reset     - clock, asynchronous active-low reset
//   sns5, sns10    - raw bouncy coin sensors
//   hold           - downstream busy; blocks issue while high (sampled in IDLE)
//   clr_credit     - one-cycle pulse zeroing delivered credit
//   coin           - registered coin code (00 none, 01 Rs 5, 10 Rs 10)
//   reject         - registered one-cycle coin-return pulse
//   credit         - registered delivered credit in rupees
//   fifo_full      - registered queue-full flag
//
// state    | meaning
// ST_IDLE  | coin=00, waiting for a queued coin with hold low
// ST_ISSUE | popped coin code driven on coin for one cycle
// ST_GAP   | coin=00 spacer cycle before the next issue
module coin_acceptor
  import coin_acceptor_pkg::*;
#(
  parameter int DEB_CYC    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_CREDIT = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sns5,
  input  logic       sns10,
  input  logic       hold,
  input  logic       clr_credit,
  output logic [1:0] coin,
  output logic       reject,
  output logic [5:0] credit,
  output logic       fifo_full
);

  localparam int            PW      = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]   DEPTH_C = (PW + 1)'(FIFO_DEPTH);
  localparam logic [7:0]    MAX_C   = 8'(MAX_CREDIT);

  logic             evt5, evt10;
  logic [1:0]       mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW:0]      count, count_next;
  logic [6:0]       queued_sum;
  issue_state_t     state;

  logic             both, single, push, pop;
  logic [1:0]       in_code;
  logic [6:0]       in_val, head_val;
  logic [7:0]       total;

  coin_debounce #(.DEB_CYC(DEB_CYC)) u_deb5 (
    .clk   (clk),
    .reset (reset),
    .sns   (sns5),
    .evt   (evt5)
  );

  coin_debounce #(.DEB_CYC(DEB_CYC)) u_deb10 (
    .clk   (clk),
    .reset (reset),
    .sns   (sns10),
    .evt   (evt10)
  );

  // Admission compares against credit plus everything already queued, so the
  // credit can never overshoot MAX_CREDIT once the queue drains. A pop in the
  // same cycle moves value from queued_sum to credit and leaves the sum intact.
  always_comb begin
    both       = evt5 & evt10;
    single     = evt5 ^ evt10;
    in_code    = evt10 ? COIN_10 : COIN_5;
    in_val     = coin_value(in_code);
    total      = {2'b00, credit} + {1'b0, queued_sum} + {1'b0, in_val};
    push       = single && (count != DEPTH_C) && (total <= MAX_C);
    pop        = (state == ST_IDLE) && (count != '0) && !hold;
    head_val   = coin_value(mem[rd_ptr]);
    count_next = count + (PW + 1)'(push) - (PW + 1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_code;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      queued_sum <= 7'd0;
      fifo_full  <= 1'b0;
      reject     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count      <= count_next;
      fifo_full  <= (count_next == DEPTH_C);
      queued_sum <= queued_sum + (push ? in_val : 7'd0) - (pop ? head_val : 7'd0);
      reject     <= both | (single & ~push);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      coin   <= COIN_NONE;
      credit <= 6'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          coin <= COIN_NONE;
          if (pop) begin
            coin  <= mem[rd_ptr];
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          coin  <= COIN_NONE;
          state <= ST_GAP;
        end
        ST_GAP: begin
          coin  <= COIN_NONE;
          state <= ST_IDLE;
        end
        default: begin
          coin  <= COIN_NONE;
          state <= ST_IDLE;
        end
      endcase

      // A clear coinciding with a pop keeps only the popped coin's value.
      if (pop)
        credit <= (clr_credit ? 6'd0 : credit) + head_val[5:0];
      else if (clr_credit)
        credit <= 6'd0;
    end
  end

endmodule

// File: doc/coin_acceptor.md
COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 Parameter DEB_CYC, default 4: consecutive synchronized-high cycles needed to accept a sensor pulse; legal range 1..15.
REQ-002 Parameter FIFO_DEPTH, default 4: coin queue depth; power of two, 2..8.
REQ-003 Parameter MAX_CREDIT, default 50: credit ceiling in rupees; multiple of 5, at most 63.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 sns5  in  1  raw, asynchronous, bouncy Rs 5 coin sensor; high while a coin passes.
REQ-007 sns10  in  1  raw, asynchronous, bouncy Rs 10 coin sensor; high while a coin passes.
REQ-008 hold  in  1  downstream busy; while high, no coin is issued.
REQ-009 clr_credit  in  1  one-cycle pulse from downstream on vend or cancel; zeroes delivered credit.
REQ-010 coin  out  2  registered coin code to the vending FSM: 00 none, 01 Rs 5, 10 Rs 10; 11 never driven.
REQ-011 reject  out  1  registered one-cycle pulse; drives the coin-return flap.
REQ-012 credit  out  6  registered delivered credit in rupees.
REQ-013 fifo_full  out  1  registered; high when the queue holds FIFO_DEPTH entries.

Function
REQ-014 Each sensor SHALL pass through its own 2-flop synchronizer before any other logic uses it.
REQ-015 Debounce, per sensor:
- counter increments while the synchronized level is 1 and clears to 0 when it is 0;
- counter saturates at DEB_CYC;
- a coin event fires once, on the cycle the counter reaches DEB_CYC;
- no further event until the level has returned to 0.
REQ-016 Both sensors firing events in the same cycle SHALL produce reject=1 for one cycle, with nothing enqueued.
REQ-017 A single event SHALL be enqueued only if the queue is not full and credit + queued_sum + value <= MAX_CREDIT; otherwise reject=1 for one cycle.
REQ-018 queued_sum SHALL be the total rupee value of queued entries, at 7 bits; credit SHALL be 6 bits and never exceed MAX_CREDIT.
REQ-019 Issue FSM states are IDLE, ISSUE and GAP:
- IDLE -> ISSUE when the queue is non-empty and hold=0; the head entry is popped.
- ISSUE drives the popped code on coin for exactly one cycle, then -> GAP.
- GAP drives coin=00 for one cycle, then -> IDLE.
- coin=00 in IDLE and GAP.
REQ-020 Consecutive coin pulses SHALL therefore be separated by at least one 00 cycle; the peak issue rate is one coin per 3 cycles.
REQ-021 hold SHALL be sampled only in IDLE; asserting hold during ISSUE or GAP does not truncate the current pulse.
REQ-022 On pop, credit SHALL increase by the coin value (5 or 10) in the same cycle coin is driven.
REQ-023 clr_credit SHALL set credit to 0; when it coincides with a pop, credit becomes the popped coin's value.
REQ-024 Enqueue and pop in the same cycle SHALL both take effect, leaving occupancy unchanged.
REQ-025 clr_credit SHALL NOT alter queued entries or queued_sum.
REQ-026 Latency: with the queue empty, FSM in IDLE and hold=0, coin SHALL assert exactly DEB_CYC+3 cycles after the first edge sampling the sensor high.

Reset
REQ-027 reset=0 SHALL immediately force all of the following, regardless of clk:
- coin=00, reject=0, credit=0, fifo_full=0;
- FIFO empty, queued_sum=0;
- debounce counters and synchronizers to 0;
- FSM to IDLE.
REQ-028 A sensor held high across reset deassertion SHALL be treated as a fresh pulse and debounced from count 0.

Structure
REQ-029 A shared package SHALL hold:
- coin codes COIN_NONE, COIN_5, COIN_10;
- coin values 5 and 10;
- the issue FSM state enum.
REQ-030 The debouncer (synchronizer plus counter plus event edge) SHALL be sub-module coin_debounce, instantiated once per sensor; the FIFO stays inline.

Verification
REQ-031 Directed scenarios:
- Clean sns5 pulse 10 cycles, DEB_CYC=4 -> coin=01 for one cycle, 7 cycles after the first sampled edge; credit=5.
- sns10 bouncing 1-0-1 at 2-cycle spacing, then stable 8 cycles -> exactly one coin=10 pulse; no reject.
- Both sensors stable-high together -> reject pulse; coin stays 00; credit unchanged.
- hold=1; five Rs 10 coins inserted -> 4 queued, fifo_full=1, fifth rejected; on hold=0 -> four coin=10 pulses each followed by 00; credit=40.
- credit=45; Rs 10 inserted -> reject; Rs 5 inserted -> accepted, credit=50.
- clr_credit coincident with a Rs 5 pop -> credit=5; reset=0 mid-queue -> queue empty, all outputs 0.
